// File: rtl/audio_buffer_ctrl_pkg.sv
// Shared audio constants and state encodings for the sample-buffer controller.
package audio_buffer_ctrl_pkg;

    localparam int unsigned SAMPLE_W     = 18;
    localparam int unsigned CLK_DIV_44K1 = 1134;  // 50 MHz / 44.1 kHz
    localparam int unsigned CLK_DIV_48K  = 1042;  // 50 MHz / 48 kHz, rounded

    typedef enum logic [1:0] {
        W_INIT,
        W_IDLE,
        W_REQ,
        W_REL
    } w_state_t;

    typedef enum logic [1:0] {
        R_INIT,
        R_IDLE,
        R_ACK,
        R_SETTLE
    } r_state_t;

endpackage

// File: rtl/audio_buffer_ctrl_tick_gen.sv
// Sample-rate divider: one-cycle tick every CLK_DIV cycles while enabled.
module audio_tick_gen
    import audio_buffer_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_44K1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/audio_buffer_ctrl.sv
// Write/read sequencing between an upstream producer, the 64-entry sample
// buffer and the DAC-side consumer, including the post-reset clear wait.
module audio_buffer_ctrl
    import audio_buffer_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_44K1,
    parameter int unsigned ACK_HOLD    = 2,
    parameter int unsigned SETTLE      = 3,
    parameter int unsigned INIT_CYCLES = 70
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                src_valid,
    input  logic [SAMPLE_W-1:0] src_data,
    output logic                src_ready,
    output logic                buf_ready,
    input  logic                buf_received,
    output logic [SAMPLE_W-1:0] buf_din,
    input  logic                buf_full,
    output logic                buf_ack,
    input  logic                buf_valid,
    input  logic [SAMPLE_W-1:0] buf_dout,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_strobe,
    output logic [15:0]         underrun_count,
    output logic                init_done
);

    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int unsigned RD_W   = $clog2(ACK_HOLD + SETTLE + 1);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [RD_W-1:0]   ACK_LAST  = RD_W'(ACK_HOLD - 1);
    localparam logic [RD_W-1:0]   CAP_AT    = RD_W'(ACK_HOLD + SETTLE - 2);
    localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(ACK_HOLD + SETTLE - 1);

    logic [INIT_W-1:0] init_cnt;
    logic              init_fire;
    logic              tick;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [RD_W-1:0] rd_cnt;
    logic            capture;
    logic            underrun;

    audio_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign init_fire = !init_done && (init_cnt == INIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (!init_done) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_fire) begin
                init_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_INIT;
            buf_din <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && src_valid && src_ready) begin
                buf_din <= src_data;
            end
        end
    end

    always_comb begin
        w_next    = w_state;
        src_ready = 1'b0;
        buf_ready = 1'b0;
        case (w_state)
            W_INIT: if (init_fire) w_next = W_IDLE;
            W_IDLE: begin
                src_ready = !buf_full;
                if (src_valid && !buf_full) w_next = W_REQ;
            end
            W_REQ: begin
                buf_ready = 1'b1;
                if (buf_received) w_next = W_REL;
            end
            W_REL:   if (!buf_received) w_next = W_IDLE;
            default: w_next = W_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= R_INIT;
            rd_cnt         <= '0;
            sample_out     <= '0;
            sample_strobe  <= 1'b0;
            underrun_count <= '0;
        end else begin
            r_state       <= r_next;
            rd_cnt        <= (r_state == R_ACK || r_state == R_SETTLE) ? rd_cnt + 1'b1 : '0;
            sample_strobe <= 1'b0;
            if (capture) begin
                sample_out    <= buf_dout;
                sample_strobe <= 1'b1;
            end
            if (underrun) begin
                sample_strobe <= 1'b1;
                if (underrun_count != '1) begin
                    underrun_count <= underrun_count + 1'b1;
                end
            end
        end
    end

    // Capture is registered one cycle before the final settle cycle so the
    // strobe and new sample_out are visible during that final cycle.
    always_comb begin
        r_next   = r_state;
        buf_ack  = 1'b0;
        underrun = 1'b0;
        capture  = (r_state == R_ACK || r_state == R_SETTLE) && (rd_cnt == CAP_AT);
        case (r_state)
            R_INIT: if (init_fire) r_next = R_IDLE;
            R_IDLE: begin
                if (tick) begin
                    if (buf_valid) r_next = R_ACK;
                    else           underrun = 1'b1;
                end
            end
            R_ACK: begin
                buf_ack = 1'b1;
                if (rd_cnt == ACK_LAST) r_next = R_SETTLE;
            end
            R_SETTLE: if (rd_cnt == RD_LAST) r_next = R_IDLE;
            default:  r_next = R_INIT;
        endcase
    end

endmodule
